// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, function codes,
// ALU control values, FSM states and the decoded control bundle.
package ctrl_pkg;
   localparam int OP_W   = 6;
   localparam int FUNC_W = 6;
   localparam int ALUC_W = 4;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNC_W-1:0] FN_SLT = 6'b101010;
   localparam logic [FUNC_W-1:0] FN_NOP = 6'b000000;

   localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
   localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0001;
   localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0010;
   localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0011;
   localparam logic [ALUC_W-1:0] ALUC_SLT = 4'b0100;
   localparam logic [ALUC_W-1:0] ALUC_BNE = 4'b0101;
   localparam logic [ALUC_W-1:0] ALUC_BEQ = 4'b0110;
   localparam logic [ALUC_W-1:0] ALUC_NOP = 4'b1111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   // Instruction class steers the EXEC/MEM/WB sequencing.
   typedef enum logic [2:0] {
      CLS_ALU = 3'd0,
      CLS_NOP = 3'd1,
      CLS_LW  = 3'd2,
      CLS_SW  = 3'd3,
      CLS_J   = 3'd4,
      CLS_BR  = 3'd5
   } iclass_t;

   typedef struct packed {
      iclass_t           cls;
      logic [ALUC_W-1:0] aluc;
      logic              aluimm;
      logic              sext;
      logic              regrt;
      logic              m2reg;
      logic              jump;
   } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational op/func decoder producing the control bundle and an
// illegal-instruction flag.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [FUNC_W-1:0] func,
   output ctrl_t             ctrl,
   output logic              illegal
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADD:  ctrl.aluc = ALUC_ADD;
               FN_SUB:  ctrl.aluc = ALUC_SUB;
               FN_AND:  ctrl.aluc = ALUC_AND;
               FN_OR:   ctrl.aluc = ALUC_OR;
               FN_SLT:  ctrl.aluc = ALUC_SLT;
               FN_NOP: begin
                  ctrl.cls  = CLS_NOP;
                  ctrl.aluc = ALUC_NOP;
               end
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
            ctrl.aluimm = 1'b1;
            ctrl.sext   = 1'b1;
            ctrl.regrt  = 1'b1;
            case (op)
               OP_ANDI: ctrl.aluc = ALUC_AND;
               OP_ORI:  ctrl.aluc = ALUC_OR;
               OP_SLTI: ctrl.aluc = ALUC_SLT;
               default: ctrl.aluc = ALUC_ADD;
            endcase
         end
         OP_LW: begin
            ctrl.cls    = CLS_LW;
            ctrl.aluc   = ALUC_ADD;
            ctrl.aluimm = 1'b1;
            ctrl.sext   = 1'b1;
            ctrl.regrt  = 1'b1;
            ctrl.m2reg  = 1'b1;
         end
         OP_SW: begin
            ctrl.cls    = CLS_SW;
            ctrl.aluc   = ALUC_ADD;
            ctrl.aluimm = 1'b1;
            ctrl.sext   = 1'b1;
         end
         OP_BEQ: begin
            ctrl.cls  = CLS_BR;
            ctrl.aluc = ALUC_BEQ;
         end
         OP_BNE: begin
            ctrl.cls  = CLS_BR;
            ctrl.aluc = ALUC_BNE;
         end
         OP_J: begin
            ctrl.cls  = CLS_J;
            ctrl.jump = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, a latched decode register and a retired-instruction counter.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   op,
   input  logic [FUNC_W-1:0] func,
   input  logic              z,
   input  logic              mem_ready,
   output logic              imem_req,
   output logic              dmem_rd,
   output logic              wmem,
   output logic              ir_write,
   output logic              pc_write,
   output logic              jump,
   output logic              branch,
   output logic              m2reg,
   output logic [ALUC_W-1:0] aluc,
   output logic              shift,
   output logic              aluimm,
   output logic              sext,
   output logic              regrt,
   output logic              wreg,
   output logic              illegal,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [2:0]        state_o
);

   state_t           state_reg, state_next;
   ctrl_t            dec_reg;
   ctrl_t            dec_ctrl;
   logic             dec_illegal;
   logic [CNT_W-1:0] cnt_reg;

   ctrl_decode u_decode (
      .op      (op),
      .func    (func),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_FETCH;
         dec_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_DECODE)
            dec_reg <= dec_ctrl;
         // The illegal path also writes the PC but does not retire.
         if (pc_write && !illegal)
            cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = ST_FETCH;
      case (state_reg)
         ST_FETCH:  state_next = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: state_next = dec_illegal ? ST_FETCH : ST_EXEC;
         ST_EXEC: begin
            case (dec_reg.cls)
               CLS_ALU:        state_next = ST_WB;
               CLS_LW, CLS_SW: state_next = ST_MEM;
               default:        state_next = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (!mem_ready)
               state_next = ST_MEM;
            else
               state_next = (dec_reg.cls == CLS_LW) ? ST_WB : ST_FETCH;
         end
         default:   state_next = ST_FETCH;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      dmem_rd  = 1'b0;
      wmem     = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      jump     = 1'b0;
      branch   = 1'b0;
      m2reg    = 1'b0;
      aluc     = '0;
      shift    = 1'b0;
      aluimm   = 1'b0;
      sext     = 1'b0;
      regrt    = 1'b0;
      wreg     = 1'b0;
      illegal  = 1'b0;
      state_o  = 3'd0;
      // Reset forces every output low, aborting any access in flight.
      if (!rst) begin
         if (state_reg == ST_EXEC || state_reg == ST_MEM || state_reg == ST_WB) begin
            aluc   = dec_reg.aluc;
            aluimm = dec_reg.aluimm;
            sext   = dec_reg.sext;
            regrt  = dec_reg.regrt;
            m2reg  = dec_reg.m2reg;
            jump   = dec_reg.jump;
         end
         case (state_reg)
            ST_FETCH: begin
               state_o  = 3'd0;
               imem_req = 1'b1;
               ir_write = mem_ready;
            end
            ST_DECODE: begin
               state_o  = 3'd1;
               illegal  = dec_illegal;
               pc_write = dec_illegal;
            end
            ST_EXEC: begin
               state_o  = 3'd2;
               pc_write = (dec_reg.cls == CLS_NOP) || (dec_reg.cls == CLS_J) ||
                          (dec_reg.cls == CLS_BR);
               branch   = (dec_reg.cls == CLS_BR) && z;
            end
            ST_MEM: begin
               state_o  = 3'd3;
               dmem_rd  = (dec_reg.cls == CLS_LW);
               wmem     = (dec_reg.cls == CLS_SW);
               pc_write = (dec_reg.cls == CLS_SW) && mem_ready;
            end
            ST_WB: begin
               state_o  = 3'd4;
               wreg     = 1'b1;
               pc_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign retired_cnt = rst ? '0 : cnt_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven check of the multi-cycle control unit, plus hand sequences for
// reset, reset abort in MEM and retired-counter wrap (2-bit counter instance).
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op;
   logic [5:0]  func;
   logic        z;
   logic        mem_ready;
   logic        imem_req, dmem_rd, wmem, ir_write, pc_write, jump, branch, m2reg;
   logic [3:0]  aluc;
   logic        shift, aluimm, sext, regrt, wreg, illegal;
   logic [31:0] retired_cnt;
   logic [2:0]  state_o;

   logic        s_imem_req, s_dmem_rd, s_wmem, s_ir_write, s_pc_write, s_jump, s_branch, s_m2reg;
   logic [3:0]  s_aluc;
   logic        s_shift, s_aluimm, s_sext, s_regrt, s_wreg, s_illegal;
   logic [1:0]  s_retired_cnt;
   logic [2:0]  s_state_o;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
      .imem_req(imem_req), .dmem_rd(dmem_rd), .wmem(wmem), .ir_write(ir_write),
      .pc_write(pc_write), .jump(jump), .branch(branch), .m2reg(m2reg), .aluc(aluc),
      .shift(shift), .aluimm(aluimm), .sext(sext), .regrt(regrt), .wreg(wreg),
      .illegal(illegal), .retired_cnt(retired_cnt), .state_o(state_o)
   );

   multicycle_control_unit #(.CNT_W(2)) u_dut_small (
      .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
      .imem_req(s_imem_req), .dmem_rd(s_dmem_rd), .wmem(s_wmem), .ir_write(s_ir_write),
      .pc_write(s_pc_write), .jump(s_jump), .branch(s_branch), .m2reg(s_m2reg), .aluc(s_aluc),
      .shift(s_shift), .aluimm(s_aluimm), .sext(s_sext), .regrt(s_regrt), .wreg(s_wreg),
      .illegal(s_illegal), .retired_cnt(s_retired_cnt), .state_o(s_state_o)
   );

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] func;
      logic       z;
      int         waits;
      int         cycles;
      int         aluc;
      int         wreg;
      int         regrt;
      int         aluimm;
      int         sext;
      int         m2reg;
      int         jump;
      int         branch;
      int         dmem;
      int         wmem;
      int         illegal;
      int         retire;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int any_output();
      return int'(|{imem_req, dmem_rd, wmem, ir_write, pc_write, jump, branch, m2reg,
                    aluc, shift, aluimm, sext, regrt, wreg, illegal, retired_cnt, state_o});
   endfunction

   // Entered and left 1 ns after a rising edge with the DUT in FETCH.
   task automatic apply(input vec_t v);
      int  cyc = 0, ir_cyc = 0, aluc_x = 0, regrt_x = 0, aluimm_x = 0, sext_x = 0;
      int  wreg_n = 0, m2reg_n = 0, jump_n = 0, branch_n = 0, dmem_n = 0, wmem_n = 0, ill_n = 0;
      int  waits = v.waits;
      bit  done = 1'b0;
      op = v.op; func = v.func; z = v.z;
      for (int c = 1; c <= 24 && !done; c++) begin
         if (state_o == 3'd3 && waits > 0) begin
            mem_ready = 1'b0;
            waits--;
         end else begin
            mem_ready = 1'b1;
         end
         @(negedge clk);
         cyc = c;
         if (ir_write) ir_cyc = c;
         if (state_o == 3'd2) begin
            aluc_x   = int'(aluc);
            regrt_x  = int'(regrt);
            aluimm_x = int'(aluimm);
            sext_x   = int'(sext);
         end
         wreg_n   += int'(wreg);
         m2reg_n  += int'(m2reg && wreg);
         jump_n   += int'(jump);
         branch_n += int'(branch);
         dmem_n   += int'(dmem_rd);
         wmem_n   += int'(wmem);
         ill_n    += int'(illegal);
         if (pc_write) done = 1'b1;
         @(posedge clk);
         #1;
      end
      chk({v.name, "_completed"}, int'(done), 1);
      if (v.retire != 0) exp_cnt++;
      chk({v.name, "_cycles"},  cyc,      v.cycles);
      chk({v.name, "_ir_cycle"}, ir_cyc,  1);
      chk({v.name, "_aluc"},    aluc_x,   v.aluc);
      chk({v.name, "_wreg"},    wreg_n,   v.wreg);
      chk({v.name, "_regrt"},   regrt_x,  v.regrt);
      chk({v.name, "_aluimm"},  aluimm_x, v.aluimm);
      chk({v.name, "_sext"},    sext_x,   v.sext);
      chk({v.name, "_m2reg"},   m2reg_n,  v.m2reg);
      chk({v.name, "_jump"},    jump_n,   v.jump);
      chk({v.name, "_branch"},  branch_n, v.branch);
      chk({v.name, "_dmem_rd"}, dmem_n,   v.dmem);
      chk({v.name, "_wmem"},    wmem_n,   v.wmem);
      chk({v.name, "_illegal"}, ill_n,    v.illegal);
      chk({v.name, "_retired"}, int'(retired_cnt), exp_cnt);
      chk({v.name, "_retired_small"}, int'(s_retired_cnt), exp_cnt % 4);
      $display("instr %-8s cycles=%0d aluc=%0d retired=%0d", v.name, cyc, aluc_x, retired_cnt);
   endtask

   initial begin
      //          name        op         func       z  wt cyc aluc wr rt im sx m2 j  br dm wm il ret
      vecs[0]  = '{"add",     6'b000000, 6'b100000, 0, 0, 4,  0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[1]  = '{"sub",     6'b000000, 6'b100010, 0, 0, 4,  1,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[2]  = '{"and",     6'b000000, 6'b100100, 0, 0, 4,  2,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[3]  = '{"or",      6'b000000, 6'b100101, 0, 0, 4,  3,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[4]  = '{"slt",     6'b000000, 6'b101010, 0, 0, 4,  4,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[5]  = '{"nop",     6'b000000, 6'b000000, 0, 0, 3,  15,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[6]  = '{"addi",    6'b001000, 6'b000000, 0, 0, 4,  0,   1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
      vecs[7]  = '{"andi",    6'b001100, 6'b010101, 0, 0, 4,  2,   1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
      vecs[8]  = '{"ori",     6'b001101, 6'b000000, 0, 0, 4,  3,   1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
      vecs[9]  = '{"slti",    6'b001010, 6'b000000, 0, 0, 4,  4,   1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
      vecs[10] = '{"lw",      6'b100011, 6'b000000, 0, 0, 5,  0,   1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1};
      vecs[11] = '{"lw_wait", 6'b100011, 6'b000000, 0, 3, 8,  0,   1, 1, 1, 1, 1, 0, 0, 4, 0, 0, 1};
      vecs[12] = '{"sw",      6'b101011, 6'b000000, 0, 0, 4,  0,   0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1};
      vecs[13] = '{"sw_wait", 6'b101011, 6'b000000, 0, 2, 6,  0,   0, 0, 1, 1, 0, 0, 0, 0, 3, 0, 1};
      vecs[14] = '{"beq_t",   6'b000100, 6'b000000, 1, 0, 3,  6,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
      vecs[15] = '{"beq_nt",  6'b000100, 6'b000000, 0, 0, 3,  6,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[16] = '{"bne_t",   6'b000101, 6'b000000, 1, 0, 3,  5,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
      vecs[17] = '{"j",       6'b000010, 6'b000000, 0, 0, 3,  0,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      vecs[18] = '{"ill_op",  6'b111111, 6'b000000, 0, 0, 2,  0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[19] = '{"ill_fn",  6'b000000, 6'b000001, 0, 0, 2,  0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

      rst = 1'b1; op = '0; func = '0; z = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("reset_outputs_zero", any_output(), 0);
      chk("reset_retired_zero", int'(retired_cnt), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_state", int'(state_o), 0);
      chk("post_reset_imem_req", int'(imem_req), 1);
      chk("post_reset_ir_write_held", int'(ir_write), 0);
      $display("reset released state=%0d imem_req=%0d", state_o, imem_req);
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) apply(vecs[i]);

      // sw aborted by reset while waiting in MEM
      op = 6'b101011; func = '0; z = 1'b0; mem_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b0;
      @(negedge clk);
      chk("sw_abort_in_mem", int'(state_o), 3);
      chk("sw_abort_wmem_before", int'(wmem), 1);
      @(posedge clk);
      #1;
      rst = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      chk("sw_abort_outputs_zero", any_output(), 0);
      chk("sw_abort_no_pc_write", int'(pc_write), 0);
      exp_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("sw_abort_fetch_state", int'(state_o), 0);
      chk("sw_abort_fetch_req", int'(imem_req), 1);
      chk("sw_abort_retired", int'(retired_cnt), 0);
      $display("sw abort: state=%0d retired=%0d", state_o, retired_cnt);
      @(posedge clk);
      #1;

      // Four jumps take the 2-bit counter through its wrap back to zero.
      for (int i = 0; i < 4; i++) apply(vecs[17]);
      chk("wrap_small_zero", int'(s_retired_cnt), 0);
      chk("wrap_wide_four", int'(retired_cnt), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
